// File: rtl/microarch_defs.sv
// microarch_defs: shared CPU-core micro-architecture definitions.
//   alu_op_t    : 2-bit ALU opcode as driven onto the ALU's alu_op input
//   ALU_*       : opcode constants understood by the ALU
//   arb_state_t : sequencing states of the ALU arbiter
package microarch_defs;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 2'b00;
  localparam alu_op_t ALU_SUB = 2'b01;
  localparam alu_op_t ALU_AND = 2'b10;
  localparam alu_op_t ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAP_RES = 3'd2,
    CAP_FLG = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares the single registered ALU between the control unit (req0)
// and the aux/debug port (req1). Round-robin over a valid/ready handshake, one
// operation in flight at a time, result and flags captured at the ALU's own
// latencies, one-cycle response pulse to the requester that owned the op.
//
// Ports
//   clk, reset              system clock; asynchronous active-low reset
//   reqN_valid/ready        N=0,1 request handshake (accept when both high)
//   reqN_op/a/b             N=0,1 operation and operands, stable while waiting
//   rspN_valid              N=0,1 one-cycle response pulse to the owner
//   rsp_result/zero/carry/negative  shared captured response bus
//   alu_a/alu_b/alu_op      registered drive to the ALU inputs
//   alu_result/zero/carry/negative  ALU outputs
//   busy                    high whenever an operation is in progress
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no op in flight; grant and accept a request, latch alu_* inputs
// ISSUE   | alu_* stable; ALU samples them at the end of this cycle
// CAP_RES | ALU result/carry valid; capture into rsp_result/rsp_carry
// CAP_FLG | ALU zero/negative valid; capture into rsp_zero/rsp_negative
// RESP    | one-cycle response pulse to the owner; back to IDLE
module alu_arbiter
  import microarch_defs::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,

  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_carry,
  output logic                  rsp_negative,

  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_carry,
  input  logic                  alu_negative,

  output logic                  busy
);

  arb_state_t            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  alu_op_t               alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic                  rsp_carry_q, rsp_carry_d;
  logic                  rsp_negative_q, rsp_negative_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic                  busy_q, busy_d;

  logic gnt_id;
  logic accept;

  // Round-robin: a lone requester wins outright; on a tie the one that did
  // not win last time gets it. last_grant resets to 1 so req0 wins first.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Ready is gated by reset so nothing is offered while the block is held
  // in reset, even though the state register already reads IDLE.
  assign req0_ready = reset && (state_q == IDLE) && req0_valid && !gnt_id;
  assign req1_ready = reset && (state_q == IDLE) && req1_valid &&  gnt_id;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_negative_d = rsp_negative_q;
    rsp0_valid_d   = 1'b0;
    rsp1_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          alu_op_d     = gnt_id ? req1_op : req0_op;
          alu_a_d      = gnt_id ? req1_a  : req0_a;
          alu_b_d      = gnt_id ? req1_b  : req0_b;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAP_RES;
      end
      CAP_RES: begin
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        state_d      = CAP_FLG;
      end
      CAP_FLG: begin
        rsp_zero_d     = alu_zero;
        rsp_negative_d = alu_negative;
        // Pulse registered here so it appears during RESP, with the flags.
        rsp0_valid_d   = !owner_q;
        rsp1_valid_d   =  owner_q;
        state_d        = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= ALU_ADD;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_negative_q <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_negative_q <= rsp_negative_d;
      rsp0_valid_q   <= rsp0_valid_d;
      rsp1_valid_q   <= rsp1_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_negative = rsp_negative_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: bench for alu_arbiter with a behavioural registered ALU
// (result/carry one cycle after operands, zero/negative one cycle after result).
module tb_alu_arbiter;
  import microarch_defs::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_carry, rsp_negative;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_zero, alu_carry, alu_negative;
  logic         busy;
  logic         alu_rst;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_negative(rsp_negative),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative),
    .busy(busy)
  );

  // Behavioural ALU with active-high reset driven from ~reset.
  assign alu_rst = ~reset;
  always @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      alu_result   <= '0;
      alu_carry    <= 1'b0;
      alu_zero     <= 1'b0;
      alu_negative <= 1'b0;
    end else begin
      case (alu_op)
        ALU_ADD: {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
        ALU_SUB: {alu_carry, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
        ALU_AND: {alu_carry, alu_result} <= {1'b0, alu_a & alu_b};
        default: {alu_carry, alu_result} <= {1'b0, alu_a | alu_b};
      endcase
      alu_zero     <= (alu_result == '0);
      alu_negative <= alu_result[W-1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // Scoreboard: expected response pushed at accept, popped at the pulse.
  typedef struct {
    bit         port;
    int         cyc;
    logic [7:0] res;
    logic       z, c, n;
  } sb_t;

  sb_t sb[$];
  bit  acc_port[$];
  int  acc_cyc[$];

  function automatic sb_t ref_alu(input bit port, input int c, input logic [1:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
    sb_t        r;
    logic [8:0] s;
    case (op)
      2'b00:   s = {1'b0, a} + {1'b0, b};
      2'b01:   s = {1'b0, a} - {1'b0, b};
      2'b10:   s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    r.port = port;
    r.cyc  = c + 4;
    r.res  = s[7:0];
    r.c    = s[8];
    r.z    = (s[7:0] == 8'h00);
    r.n    = s[7];
    return r;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    bit  p;
    if (!reset) begin
      sb.delete();
    end else begin
      if (req0_valid && req0_ready && req1_ready) chk("dual_ready", 32'd1, 32'd0);
      if (req0_valid && req0_ready) begin
        sb.push_back(ref_alu(1'b0, cyc, req0_op, req0_a, req0_b));
        acc_port.push_back(1'b0);
        acc_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(ref_alu(1'b1, cyc, req1_op, req1_a, req1_b));
        acc_port.push_back(1'b1);
        acc_cyc.push_back(cyc);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (rsp0_valid && rsp1_valid) chk("dual_rsp", 32'd1, 32'd0);
        p = rsp1_valid;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(p), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("sb_owner",  32'(p),            32'(e.port));
          chk("sb_cycle",  32'(cyc),          32'(e.cyc));
          chk("sb_result", 32'(rsp_result),   32'(e.res));
          chk("sb_zero",   32'(rsp_zero),     32'(e.z));
          chk("sb_carry",  32'(rsp_carry),    32'(e.c));
          chk("sb_neg",    32'(rsp_negative), 32'(e.n));
        end
      end
    end
  end

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Call just after a posedge. Returns just after the accepting posedge.
  task automatic issue(input bit port, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int acc);
    bit done = 1'b0;
    acc = -1;
    if (port) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (port ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        acc  = cyc;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Waits on negedges for the port's pulse; returns at that negedge.
  task automatic wait_rsp(input bit port, output int at);
    bit done = 1'b0;
    at = -1;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (port ? rsp1_valid : rsp0_valid) begin
        at   = cyc;
        done = 1'b1;
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    bit         port;
    logic [1:0] op;
    logic [7:0] a, b;
    logic [7:0] res;
    logic       z, c, n;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acc, at, pulses, busy_seen;
    logic [7:0] sa, sb_;
    logic [1:0] sop;

    vecs[0] = '{1'b0, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, ALU_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, ALU_AND, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, ALU_OR,  8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, ALU_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, ALU_AND, 8'hFF, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1};

    clear_inputs();
    do_reset();

    // Reset values.
    @(negedge clk);
    chk("rst_outputs", {rsp0_valid, rsp1_valid, rsp_zero, rsp_carry, rsp_negative,
                        busy, req0_ready, req1_ready, alu_op, rsp_result, alu_a}, 32'd0);
    @(posedge clk); #1;

    // 1: reset asserted in CAP_RES drops the op silently.
    issue(1'b0, ALU_ADD, 8'h05, 8'h03, acc);
    @(negedge clk);
    chk("t1_busy_issue", 32'(busy), 32'd1);
    chk("t1_alu_a", 32'(alu_a), 32'h05);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t1_rst_outputs", {rsp0_valid, rsp1_valid, rsp_zero, rsp_carry, rsp_negative,
                           busy, req0_ready, req1_ready, alu_op, rsp_result, alu_a}, 32'd0);
    chk("t1_alu_b", 32'(alu_b), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) pulses++;
      if (busy) pulses++;
    end
    chk("t1_no_rsp", 32'(pulses), 32'd0);
    @(posedge clk); #1;

    // 2,3,5 and more: table-driven single ops.
    foreach (vecs[i]) begin
      issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, acc);
      wait_rsp(vecs[i].port, at);
      chk($sformatf("v%0d_latency", i), 32'(at - acc), 32'd4);
      chk($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
      chk($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_carry", i), 32'(rsp_carry), 32'(vecs[i].c));
      chk($sformatf("v%0d_neg", i), 32'(rsp_negative), 32'(vecs[i].n));
      chk($sformatf("v%0d_other_quiet", i), 32'(vecs[i].port ? rsp0_valid : rsp1_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_width", i), 32'(rsp0_valid || rsp1_valid), 32'd0);
      @(posedge clk); #1;
    end

    // 4: both valid from reset and held -> 0,1,0 with accepts 5 cycles apart.
    clear_inputs();
    reset = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 8'h09; req1_b = 8'h04;
    @(posedge clk); #1;
    chk("t4_ready_in_reset", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    acc_port.delete(); acc_cyc.delete();
    reset = 1'b1;
    for (int i = 0; i < 30 && acc_port.size() < 3; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t4_accepts", 32'(acc_port.size()), 32'd3);
    if (acc_port.size() >= 3) begin
      chk("t4_grant0", 32'(acc_port[0]), 32'd0);
      chk("t4_grant1", 32'(acc_port[1]), 32'd1);
      chk("t4_grant2", 32'(acc_port[2]), 32'd0);
      chk("t4_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      chk("t4_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
    end
    wait_rsp(1'b0, at);
    @(posedge clk); #1;

    // 6: req0 raised while busy and withdrawn before IDLE is never taken.
    acc_port.delete(); acc_cyc.delete();
    issue(1'b1, ALU_OR, 8'h12, 8'h34, acc);
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 8'hAA; req0_b = 8'h55;
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b0;
    wait_rsp(1'b1, at);
    chk("t6_rsp_result", 32'(rsp_result), 32'h36);
    sa = alu_a; sb_ = alu_b; sop = alu_op;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (alu_a !== sa || alu_b !== sb_ || alu_op !== sop) busy_seen += 100;
    end
    chk("t6_alu_a_held", 32'(sa), 32'h12);
    chk("t6_alu_op_held", 32'(sop), 32'(ALU_OR));
    chk("t6_idle_quiet", 32'(busy_seen), 32'd0);
    chk("t6_accepts", 32'(acc_port.size()), 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
